reminder_sequencer: RTL and testbench

REMINDER_SEQUENCER -- requirements
Module: reminder_sequencer

---
 rtl/reminder_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_reminder_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reminder_sequencer.sv
// Multi-channel reminder beeper: arms channels on req rising edges and
// plays prioritised beep bursts on a square-wave speaker until acked.
//
// Ports:
//   clk, reset (async, active-low)
//   req[NUM_CH]        level requests, rising edge arms a channel
//   ack[NUM_CH]        one-cycle pulses, clear the matching channel
//   tone_half          per-channel half-period, DIV_W bits per channel
//   beeps              per-channel beeps per burst, 4 bits per channel
//   mute               gates the speaker output only
//   speaker            square-wave drive
//   active_ch          channel currently owning the sequencer
//   busy               high whenever the FSM is not idle
//   pending[NUM_CH]    armed-channel flags
module reminder_sequencer #(
    parameter int NUM_CH   = 3,
    parameter int DIV_W    = 16,
    parameter int TICK_DIV = 100000,
    parameter int ON_T     = 200,
    parameter int OFF_T    = 200,
    parameter int GAP_T    = 1000,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       ack,
    input  logic [NUM_CH*DIV_W-1:0] tone_half,
    input  logic [NUM_CH*4-1:0]     beeps,
    input  logic                    mute,
    output logic                    speaker,
    output logic [CH_W-1:0]         active_ch,
    output logic                    busy,
    output logic [NUM_CH-1:0]       pending
);

    localparam int TK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PH_A   = (ON_T > OFF_T) ? ON_T : OFF_T;
    localparam int PH_MAX = (PH_A > GAP_T) ? PH_A : GAP_T;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        BEEP_ON,
        BEEP_OFF,
        GAP
    } state_t;

    state_t              state, state_n;
    logic [NUM_CH-1:0]   req_q;
    logic [NUM_CH-1:0]   pending_n;
    logic [TK_W-1:0]     tk, tk_n;
    logic [PH_W-1:0]     ph, ph_n;
    logic [3:0]          bcnt, bcnt_n;
    logic [CH_W-1:0]     act, act_n;
    logic [DIV_W-1:0]    hc, hc_n;
    logic                spk, spk_n;
    logic [CH_W-1:0]     sel;
    logic                tick;
    logic                enter_on;
    logic                ph_done;

    logic [DIV_W-1:0]    half_a [NUM_CH];
    logic [3:0]          beep_a [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign half_a[g] = tone_half[g*DIV_W +: DIV_W];
        assign beep_a[g] = beeps[g*4 +: 4];
    end

    // A zero half-period behaves like 1: toggle every cycle.
    function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] h);
        return (h == '0) ? '0 : h - DIV_W'(1);
    endfunction

    function automatic logic [3:0] beep_load(input logic [3:0] b);
        return (b == 4'd0) ? 4'd1 : b;
    endfunction

    // Ack beats a simultaneous rising edge.
    assign pending_n = (pending | (req & ~req_q)) & ~ack;

    assign tick    = (tk == TK_W'(TICK_DIV - 1));
    assign ph_done = tick && (ph <= PH_W'(1));

    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) sel = CH_W'(i);
        end
    end

    always_comb begin
        state_n  = state;
        tk_n     = tick ? '0 : tk + TK_W'(1);
        ph_n     = ph;
        bcnt_n   = bcnt;
        act_n    = act;
        hc_n     = hc;
        spk_n    = 1'b0;
        enter_on = 1'b0;

        unique case (state)
            IDLE: begin
                if (|pending) begin
                    state_n  = BEEP_ON;
                    act_n    = sel;
                    bcnt_n   = beep_load(beep_a[sel]);
                    tk_n     = '0;
                    enter_on = 1'b1;
                end
            end
            BEEP_ON: begin
                if (hc == '0) begin
                    spk_n = ~spk;
                    hc_n  = reload(half_a[act]);
                end else begin
                    spk_n = spk;
                    hc_n  = hc - DIV_W'(1);
                end
                if (ph_done) begin
                    state_n = BEEP_OFF;
                    ph_n    = PH_W'(OFF_T);
                    bcnt_n  = bcnt - 4'd1;
                end else if (tick) begin
                    ph_n = ph - PH_W'(1);
                end
            end
            BEEP_OFF: begin
                if (ph_done) begin
                    if (bcnt != 4'd0) begin
                        state_n  = BEEP_ON;
                        enter_on = 1'b1;
                    end else begin
                        state_n = GAP;
                        ph_n    = PH_W'(GAP_T);
                    end
                end else if (tick) begin
                    ph_n = ph - PH_W'(1);
                end
            end
            GAP: begin
                if (ph_done) begin
                    if (|pending) begin
                        state_n  = BEEP_ON;
                        act_n    = sel;
                        bcnt_n   = beep_load(beep_a[sel]);
                        enter_on = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (tick) begin
                    ph_n = ph - PH_W'(1);
                end
            end
        endcase

        // Losing the owning channel aborts the burst at this edge.
        if (state != IDLE && !pending_n[act]) begin
            state_n  = IDLE;
            enter_on = 1'b0;
        end

        if (enter_on) begin
            ph_n  = PH_W'(ON_T);
            hc_n  = reload(half_a[act_n]);
            spk_n = 1'b0;
        end

        if (state_n != BEEP_ON) spk_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            req_q   <= '0;
            pending <= '0;
            tk      <= '0;
            ph      <= '0;
            bcnt    <= '0;
            act     <= '0;
            hc      <= '0;
            spk     <= 1'b0;
        end else begin
            state   <= state_n;
            req_q   <= req;
            pending <= pending_n;
            tk      <= tk_n;
            ph      <= ph_n;
            bcnt    <= bcnt_n;
            act     <= act_n;
            hc      <= hc_n;
            spk     <= spk_n;
        end
    end

    assign speaker   = spk & ~mute;
    assign active_ch = act;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_reminder_sequencer.sv
// Directed bench for reminder_sequencer with short tick timing.
// Steps land 1 time unit after a rising clk edge.
module tb_reminder_sequencer;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH*DIV_W-1:0] tone_half;
    logic [NUM_CH*4-1:0]     beeps;
    logic                    mute;
    logic                    speaker;
    logic [1:0]              active_ch;
    logic                    busy;
    logic [NUM_CH-1:0]       pending;

    int nerr = 0;
    int nchk = 0;

    reminder_sequencer #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .TICK_DIV (10),
        .ON_T     (2),
        .OFF_T    (1),
        .GAP_T    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .tone_half (tone_half),
        .beeps     (beeps),
        .mute      (mute),
        .speaker   (speaker),
        .active_ch (active_ch),
        .busy      (busy),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        ack       = '0;
        mute      = 1'b0;
        tone_half = {16'd2, 16'd4, 16'd3};
        beeps     = {4'd1, 4'd2, 4'd0};
        #3;
        check("rst_speaker", speaker, 0);
        check("rst_busy", busy, 0);
        check("rst_active", active_ch, 0);
        check("rst_pending", pending, 0);
        cyc(2);
        reset = 1'b1;

        // Channel 1: 2 beeps, half-period 4, entry E two edges later.
        req = 3'b010;
        cyc(2);
        check("c1_busy", busy, 1);
        check("c1_active", active_ch, 1);
        check("c1_pending", pending, 3'b010);
        check("c1_spk_e0", speaker, 0);
        req = 3'b000;
        cyc(4);
        check("c1_spk_e4", speaker, 1);
        cyc(4);
        check("c1_spk_e8", speaker, 0);
        cyc(4);
        check("c1_spk_e12", speaker, 1);
        cyc(8);
        check("c1_spk_off", speaker, 0);
        check("c1_busy_off", busy, 1);
        cyc(13);
        check("c1_spk_e33", speaker, 0);
        cyc(1);
        check("c1_spk_e34", speaker, 1);
        cyc(46);
        check("c1_gap_spk", speaker, 0);
        check("c1_gap_busy", busy, 1);
        check("c1_gap_pend", pending, 3'b010);
        cyc(13);
        check("c1_rep_e93", speaker, 0);
        cyc(1);
        check("c1_rep_e94", speaker, 1);

        // Mute gates the output but not the tone phase.
        mute = 1'b1;
        cyc(1);
        check("mute_e95", speaker, 0);
        cyc(7);
        check("mute_e102", speaker, 0);
        mute = 1'b0;
        #1;
        check("unmute_phase", speaker, 1);

        // Ack mid BEEP_ON aborts to idle next edge.
        cyc(1);
        ack = 3'b010;
        cyc(1);
        ack = 3'b000;
        check("ack_busy", busy, 0);
        check("ack_spk", speaker, 0);
        check("ack_pend", pending, 0);

        // Channel 2 plays; channel 0 arms mid burst and waits for GAP end.
        req = 3'b100;
        cyc(2);
        check("c2_busy", busy, 1);
        check("c2_active", active_ch, 2);
        cyc(2);
        check("c2_spk_g2", speaker, 1);
        cyc(3);
        req = 3'b101;
        cyc(2);
        check("c0_pend", pending, 3'b101);
        check("c2_keep", active_ch, 2);
        cyc(52);
        check("c2_gap_act", active_ch, 2);
        check("c2_gap_busy", busy, 1);
        check("c2_gap_spk", speaker, 0);
        cyc(1);
        check("arb_act", active_ch, 0);
        check("arb_busy", busy, 1);
        req = 3'b000;
        ack = 3'b101;
        cyc(1);
        ack = 3'b000;
        check("c02_busy", busy, 0);
        check("c02_pend", pending, 0);

        // Ack and rising edge together: ack wins.
        req = 3'b001;
        ack = 3'b001;
        cyc(1);
        ack = 3'b000;
        check("tie_pend", pending, 0);
        cyc(3);
        check("tie_busy", busy, 0);
        check("tie_pend2", pending, 0);
        req = 3'b000;
        cyc(1);

        // Reset mid BEEP_ON, req held across release.
        req = 3'b001;
        cyc(2);
        check("r_busy", busy, 1);
        cyc(5);
        check("r_spk_pre", speaker, 1);
        reset = 1'b0;
        #1;
        check("r_spk", speaker, 0);
        check("r_busy0", busy, 0);
        check("r_pend0", pending, 0);
        check("r_act0", active_ch, 0);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        check("rr_pend", pending, 3'b001);
        check("rr_busy0", busy, 0);
        cyc(1);
        check("rr_busy", busy, 1);
        cyc(3);
        check("rr_spk", speaker, 1);
        cyc(27);
        check("rr_off_busy", busy, 1);
        check("rr_off_spk", speaker, 0);
        cyc(3);
        check("rr_one_beep", speaker, 0);
        ack = 3'b001;
        cyc(1);
        ack = 3'b000;
        check("rr_done", busy, 0);
        req = 3'b000;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
